uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
- Receive half of the board UART link.
- Oversamples the asynchronous serial line with an internal bit-period counter.
- Accepts 8N1 frames, LSB first, and presents each received byte with a one-cycle done pulse.
- Feeds the byte-processing logic whose results go out through the transmitter. Gated by the same global enable `in` as the transmitter.

Parameters:
- CLKS_PER_BIT, 5208: clk cycles per bit period (50 MHz / 9600 baud); must be >= 4.
- HALF_BIT, CLKS_PER_BIT/2: cycles from the start-edge detect to the start-bit mid-point sample.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; one clock, synchronous active-low reset (rst_n sampled on posedge clk)
- in  input  1  global enable; low forces idle
- rx  input  1  asynchronous serial line, idle high
- data_rx  output  8  last correctly received byte
- rx_done  output  1  one-cycle pulse: data_rx updated this cycle
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset values (rst_n low at posedge clk):
  - data_rx=0, rx_done=0, frame_err=0, busy=0, state=IDLE.
  - bit counter=0, baud counter=0.
  - Both synchronizer flops=1; edge-detect history=1.
- Synchronizer: rx passes through 2 flops (rx_s). All decisions use rx_s, so there are 2 cycles of input latency.
- Baud counter: counts 0..CLKS_PER_BIT-1 while not IDLE. It clears on every state transition and on each bit sample.
- State IDLE:
  - busy=0.
  - A falling edge on rx_s (previous sample 1, current sample 0) moves to START with the baud counter cleared.
- State START:
  - When the baud counter reaches HALF_BIT-1, sample rx_s.
  - Sample 0: go to DATA, clear bit index.
  - Sample 1 (glitch): return to IDLE. No pulse is raised.
- State DATA:
  - Each time the baud counter reaches CLKS_PER_BIT-1, sample rx_s into shift register bit [bit_idx] (LSB first), then increment bit_idx.
  - After bit 7 is sampled, go to STOP.
- State STOP: when the baud counter reaches CLKS_PER_BIT-1, sample rx_s, then go to IDLE.
  - Sample 1: next cycle data_rx <= shift register and rx_done=1 for exactly one cycle.
  - Sample 0: frame_err=1 for one cycle; data_rx unchanged.
- Latency: rx_done rises about 9.5 bit periods plus 3 clk cycles after the falling edge on rx.
- Back-to-back frames: IDLE is re-entered at the stop-bit mid-point, so a start edge arriving half a stop bit later is caught. No inter-frame gap is needed.
- Line held low after a frame error: no new start is detected until rx_s has returned high, because the edge detector needs a 1->0 transition.
- in low (synchronous, same priority order as the transmitter: rst_n, then in):
  - Forces IDLE and clears counters, shift register and pulses.
  - Clears data_rx to 0.
  - The synchronizer keeps running.
  - A frame cut off mid-reception produces no rx_done and no frame_err.
- rx_done and frame_err are never high in the same cycle.
- Counters never wrap: bit_idx is 3 bits, saturated by the state change.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1. State PARITY is inserted between DATA and STOP and sampled at CLKS_PER_BIT-1.
  - Extra output port parity_err (1 bit, reset 0).
  - At the STOP sample, a parity mismatch (XOR of the 8 data bits and the parity bit != 0) gives a one-cycle parity_err pulse. In that case data_rx is not updated and rx_done is not asserted.
  - frame_err takes precedence when both parity and stop bit are bad.
- Undefined: 8N1 as described, no PARITY state, no parity_err port.

Test Plan:
- CLKS_PER_BIT=16, send 0x55 (start 0, bits 1010_1010 LSB first, stop 1) -> one rx_done pulse, data_rx=0x55, frame_err stays 0, busy high for the whole frame.
- Drive rx low for 4 cycles, then high -> START aborts at HALF_BIT sample, state IDLE, no rx_done, no frame_err, data_rx unchanged.
- Send 0xA3 with stop bit 0 -> frame_err pulses once, data_rx keeps its previous value, no rx_done. Raise rx -> the next frame 0x0F is received correctly.
- Send 0xA5 then 0x3C back-to-back with a single stop bit each -> two rx_done pulses, data_rx=0xA5 then 0x3C.
- Send 0xFF, pull `in` low at bit 4 for 3 cycles, then high -> data_rx=0, busy=0, no pulses. Then send 0x81 -> rx_done, data_rx=0x81.
- With UART_RX_PARITY_EN: 0x07 with parity 1 -> rx_done, data_rx=0x07. 0x07 with parity 0 -> parity_err pulse, no rx_done.

Source files
------------

// File: rtl/uart_rx_core_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx_core_if: enable, serial line and received-byte bundle. Rev 1.0
// ----------------------------------------------------------------------------
interface uart_rx_core_if;
  logic       in;
  logic       rx;
  logic [7:0] data_rx;
  logic       rx_done;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;

  modport slave  (input in, rx, output data_rx, rx_done, frame_err, busy, parity_err);
  modport master (output in, rx, input data_rx, rx_done, frame_err, busy, parity_err);
`else
  modport slave  (input in, rx, output data_rx, rx_done, frame_err, busy);
  modport master (output in, rx, input data_rx, rx_done, frame_err, busy);
`endif
endinterface
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx_core: oversampling 8N1 UART receiver; UART_RX_PARITY_EN gives 8E1. Rev 1.0
// ----------------------------------------------------------------------------
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_rx_core_if.slave bus
);
  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF_M1 = CW'(HALF_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_PARITY = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3
  } state_t;
`endif

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q, prev_q;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          done_q, done_d;
  logic          ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic          par_q, par_d;
  logic          perr_q, perr_d;
`endif
  logic          rx_s;
  logic          fall;

  assign rx_s = sync2_q;
  assign fall = prev_q & ~rx_s;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (fall) state_d = S_START;
      end
      S_START: begin
        if (baud_q == C_HALF_M1) begin
          baud_d = '0;
          if (!rx_s) begin
            state_d = S_DATA;
            bit_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (baud_q == C_FULL_M1) begin
          baud_d         = '0;
          shift_d[bit_q] = rx_s;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (baud_q == C_FULL_M1) begin
          baud_d  = '0;
          par_d   = rx_s;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (baud_q == C_FULL_M1) begin
          baud_d  = '0;
          state_d = S_IDLE;
          if (!rx_s) begin
            ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (^{shift_q, par_q}) begin
            perr_d = 1'b1;
`endif
          end else begin
            done_d = 1'b1;
            data_d = shift_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Synchronizer and edge history keep running while the enable is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      sync1_q <= bus.rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (!bus.in) begin
        state_q <= S_IDLE;
        baud_q  <= '0;
        bit_q   <= '0;
        shift_q <= '0;
        data_q  <= '0;
        done_q  <= 1'b0;
        ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
        par_q   <= 1'b0;
        perr_q  <= 1'b0;
`endif
      end else begin
        state_q <= state_d;
        baud_q  <= baud_d;
        bit_q   <= bit_d;
        shift_q <= shift_d;
        data_q  <= data_d;
        done_q  <= done_d;
        ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
        par_q   <= par_d;
        perr_q  <= perr_d;
`endif
      end
    end
  end

  assign bus.data_rx    = data_q;
  assign bus.rx_done    = done_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// tb_uart_rx_core: directed plus randomized frames checked against an event-level frame model.
module tb_uart_rx_core;
  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 10;
`else
  localparam int NBITS = 9;
`endif
  // Sync (2) + edge detect (1) + half start bit + remaining bit periods.
  localparam int LAT = 3 + HALF + NBITS * CPB;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc      = 0;
  int   fall_cyc = 0;
  int   lat      = -1;
  int   errors   = 0;
  int   checks   = 0;
  int   both_cnt = 0;
  logic [7:0] exp_data = 8'h00;
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_core_if u_if();

  uart_rx_core #(.CLKS_PER_BIT(CPB), .HALF_BIT(HALF)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  // Event codes: 01_byte = rx_done with byte, 2'b10 = frame_err, 2'b11 = parity_err.
  always @(negedge clk) begin
    if (rst_n) begin
      if (u_if.rx_done) begin
        got_q.push_back({2'b01, u_if.data_rx});
        lat = cyc - fall_cyc;
      end
      if (u_if.frame_err) got_q.push_back(10'h200);
`ifdef UART_RX_PARITY_EN
      if (u_if.parity_err) got_q.push_back(10'h300);
      if ($countones({u_if.rx_done, u_if.frame_err, u_if.parity_err}) > 1) both_cnt++;
`else
      if (u_if.rx_done && u_if.frame_err) both_cnt++;
`endif
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [9:0] model(input logic [7:0] b, input logic stop, input logic par);
    if (!stop) return 10'h200;
`ifdef UART_RX_PARITY_EN
    if ((^b) != par) return 10'h300;
`endif
    return {2'b01, b};
  endfunction

  task automatic send_bit(input logic v, input bit chk, input int off);
    u_if.rx = v;
    for (int c = 0; c < CPB; c++) begin
      if (chk && c == off) check("busy_in_frame", u_if.busy, 1'b1);
      tick(1);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par, input bit chk);
    logic [9:0] ev;
    fall_cyc = cyc;
    send_bit(1'b0, chk, 12);
    for (int i = 0; i < 8; i++) send_bit(b[i], chk, 12);
`ifdef UART_RX_PARITY_EN
    send_bit(par, chk, 12);
`endif
    send_bit(stop, chk, 4);
    ev = model(b, stop, par);
    exp_q.push_back(ev);
    if (ev[9:8] == 2'b01) exp_data = b;
  endtask

  task automatic glitch(input int len);
    u_if.rx = 1'b0;
    tick(len);
    u_if.rx = 1'b1;
    tick(2 * CPB);
  endtask

  task automatic flush();
    int n;
    tick(2 * CPB);
    check("n_events", got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check("event", got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
    check("data_rx", u_if.data_rx, exp_data);
    check("busy_idle", u_if.busy, 1'b0);
  endtask

  initial begin
    logic       bad_prev;
    logic [7:0] b;
    logic       stop;
    logic       par;

    u_if.rx = 1'b1;
    u_if.in = 1'b1;
    rst_n   = 1'b0;
    tick(4);
    check("rst_data_rx", u_if.data_rx, 8'h00);
    check("rst_rx_done", u_if.rx_done, 1'b0);
    check("rst_frame_err", u_if.frame_err, 1'b0);
    check("rst_busy", u_if.busy, 1'b0);
    rst_n = 1'b1;
    tick(4);

    send_frame(8'h55, 1'b1, ^8'h55, 1'b1);
    tick(CPB);
    check("latency", lat, LAT);
    flush();

    glitch(4);
    flush();

    // Bad stop bit, then the line is held low: no new start until it rises.
    send_frame(8'hA3, 1'b0, ^8'hA3, 1'b0);
    tick(2 * CPB);
    check("busy_line_low", u_if.busy, 1'b0);
    flush();
    u_if.rx = 1'b1;
    tick(CPB);
    send_frame(8'h0F, 1'b1, ^8'h0F, 1'b0);
    flush();

    send_frame(8'hA5, 1'b1, ^8'hA5, 1'b0);
    send_frame(8'h3C, 1'b1, ^8'h3C, 1'b0);
    flush();

    // 0xFF cut off by the enable in the middle of bit 4.
    u_if.rx = 1'b0;
    tick(CPB);
    u_if.rx = 1'b1;
    tick(4 * CPB + 4);
    u_if.in = 1'b0;
    tick(3);
    u_if.in = 1'b1;
    check("busy_after_cut", u_if.busy, 1'b0);
    tick(CPB - 7 + (NBITS - 5) * CPB);
    exp_data = 8'h00;
    flush();
    send_frame(8'h81, 1'b1, ^8'h81, 1'b0);
    flush();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    flush();
`endif

    bad_prev = 1'b0;
    for (int n = 0; n < 30; n++) begin
      u_if.rx = 1'b1;
      if (bad_prev) tick($urandom_range(4, 20));
      else tick($urandom_range(0, 20));
      if ($urandom_range(0, 9) == 0) begin
        glitch($urandom_range(1, 6));
        bad_prev = 1'b0;
      end else begin
        b    = 8'($urandom_range(0, 255));
        stop = ($urandom_range(0, 4) != 0);
        par  = (^b) ^ ($urandom_range(0, 4) == 0);
        send_frame(b, stop, par, 1'b0);
        bad_prev = ~stop;
      end
      if (n % 5 == 4) flush();
    end
    flush();

    check("pulse_excl", both_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
